// File: rtl/lo_nco.sv
// Numerically controlled local oscillator: phase accumulator, phase offset,
// and a quarter-wave table unfolded to produce simultaneous sin/cos samples.
module lo_nco #(
    parameter int ACC_W = 16,
    parameter int Q     = 2,
    parameter int OUT_W = 9,
    parameter int AMP   = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic [ACC_W-1:0]        freq_word,
    input  logic [ACC_W-1:0]        phase_off,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid
);

    localparam int N  = 1 << Q;
    localparam int IW = Q + 2;

    // Integer Taylor series keeps table construction free of real arithmetic.
    function automatic int lut_val(input int i);
        longint s, x, term, sum;
        s    = 64'sd268435456;
        x    = (64'sd843314857 * longint'(i)) / longint'(2 * N);
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -(((term * x) / s) * x / s) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((longint'(AMP) * sum + s / 2) / s);
    endfunction

    logic signed [OUT_W-1:0] lut_w [0:N];

    for (genvar i = 0; i <= N; i++) begin : g_lut
        localparam int V = lut_val(i);
        assign lut_w[i] = OUT_W'(V);
    end

    localparam logic [Q:0] N_A = (Q+1)'(N);

    function automatic logic signed [OUT_W-1:0] unfold(input logic [IW-1:0] ix);
        logic [1:0]              quad;
        logic [Q:0]              ai;
        logic signed [OUT_W-1:0] mag;
        quad = ix[IW-1:Q];
        ai   = quad[0] ? (N_A - {1'b0, ix[Q-1:0]}) : {1'b0, ix[Q-1:0]};
        mag  = lut_w[ai];
        return quad[1] ? -mag : mag;
    endfunction

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [IW-1:0]           p1_q, p1_d;
    logic [1:0]              vld_pipe_q, vld_pipe_d;
    logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic [IW-1:0]           cos_idx;

    always_comb begin
        acc_d = acc_q;
        if (sync_clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + freq_word;

        // Only the table index survives the stage; the rest is truncated anyway.
        p1_d       = IW'((acc_q + phase_off) >> (ACC_W - IW));
        vld_pipe_d = {vld_pipe_q[0] & ~sync_clr, en & ~sync_clr};

        cos_idx = p1_q + IW'(N);
        sin_d   = sin_q;
        cos_d   = cos_q;
        if (sync_clr) begin
            sin_d = '0;
            cos_d = '0;
        end else if (vld_pipe_q[0]) begin
            sin_d = unfold(p1_q);
            cos_d = unfold(cos_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            p1_q       <= '0;
            vld_pipe_q <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            p1_q       <= p1_d;
            vld_pipe_q <= vld_pipe_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = vld_pipe_q[1];

endmodule

// File: tb/tb_lo_nco.sv
// Scoreboard bench for lo_nco: directed launches push hand-derived samples,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_lo_nco;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              sync_clr = 1'b0;
    logic [15:0]       freq_word = '0;
    logic [15:0]       phase_off = '0;
    logic signed [8:0] sin_out, cos_out;
    logic              out_valid;

    lo_nco #(.ACC_W(16), .Q(2), .OUT_W(9), .AMP(100)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .freq_word(freq_word), .phase_off(phase_off),
        .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sin_q[$];
    int exp_cos_q[$];
    int sin16[16] = '{0, 38, 71, 92, 100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int c);
        exp_sin_q.push_back(s);
        exp_cos_q.push_back(c);
    endtask

    task automatic cyc(input logic e, input logic c);
        en       = e;
        sync_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_sin_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_sample: got sin=%0d cos=%0d, expected no sample", sin_out, cos_out);
            end else begin
                check("sin", sin_out, exp_sin_q.pop_front());
                check("cos", cos_out, exp_cos_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        freq_word = 16'h1000;
        phase_off = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sin", sin_out, 0);
        check("rst_cos", cos_out, 0);
        #2 rst_n = 1'b1;

        // 16-point sweep at fw=0x1000
        for (int k = 0; k < 20; k++) begin
            push(sin16[k % 16], sin16[(k + 4) % 16]);
            cyc(1'b1, 1'b0);
            if (k == 0) check("first_edge_valid", out_valid, 0);
        end

        // pause three cycles after the sample with sin=92
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("hold_valid", out_valid, 0);
        check("hold_sin", sin_out, 92);
        check("hold_cos", cos_out, 38);

        // resume; the fourth launch is killed by the following sync_clr
        for (int k = 20; k < 24; k++) begin
            if (k < 23) push(sin16[k % 16], sin16[(k + 4) % 16]);
            cyc(1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1);
        check("clr_valid", out_valid, 0);
        check("clr_sin", sin_out, 0);
        check("clr_cos", cos_out, 0);
        for (int k = 0; k < 8; k++) begin
            push(sin16[k], sin16[(k + 4) % 16]);
            cyc(1'b1, 1'b0);
        end
        drain();

        freq_word = 16'h2000;
        for (int k = 0; k < 10; k++) begin
            push(sin16[(2 * k) % 16], sin16[(2 * k + 4) % 16]);
            cyc(1'b1, 1'b0);
        end
        drain();

        freq_word = 16'hF000;
        for (int k = 0; k < 10; k++) begin
            push(sin16[(16 - k) % 16], sin16[(20 - k) % 16]);
            cyc(1'b1, 1'b0);
        end
        drain();

        freq_word = 16'h1000;
        phase_off = 16'h4000;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) phase_off = 16'h0000;
            if (k < 6) push(sin16[(k + 4) % 16], sin16[(k + 8) % 16]);
            else       push(sin16[k % 16], sin16[(k + 4) % 16]);
            cyc(1'b1, 1'b0);
        end
        drain();

        freq_word = 16'h0000;
        phase_off = 16'h1000;
        for (int k = 0; k < 4; k++) begin
            push(38, 92);
            cyc(1'b1, 1'b0);
        end
        drain();
        check("queue_empty", exp_sin_q.size(), 0);

        // asynchronous reset mid-run with a nonzero sample on the outputs
        freq_word = 16'h1000;
        push(38, 92);
        cyc(1'b1, 1'b0);
        push(71, 71);
        cyc(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        exp_sin_q.delete();
        exp_cos_q.delete();
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sin", sin_out, 0);
        check("async_rst_cos", cos_out, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        check("post_rst_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lo_nco.md
Name: lo_nco

Overview:
- Parametrised numerically controlled local oscillator. Successor to the fixed 16-point sine LO.
- Phase accumulator with programmable frequency word and phase offset.
- Quarter-wave LUT with symmetry unfolding; simultaneous sin and cos outputs.
- Feeds the mixer stage. Output valid flag allows downstream gating.

Parameters:
- ACC_W, 16: phase accumulator width in bits.
- Q, 2: quarter-wave LUT address bits. Full cycle = 4*2^Q points; default gives 16 points.
- OUT_W, 9: signed output width.
- AMP, 100: peak amplitude. Must satisfy AMP <= 2^(OUT_W-1)-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance accumulator and launch a sample this cycle
- sync_clr  in  1  synchronous phase clear; priority over en
- freq_word  in  ACC_W  phase increment per enabled cycle, unsigned, sampled every cycle
- phase_off  in  ACC_W  phase offset added before lookup, sampled every cycle
- sin_out  out  OUT_W  signed sine sample
- cos_out  out  OUT_W  signed cosine sample
- out_valid  out  1  sin_out/cos_out hold a new sample this cycle

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, all pipeline registers=0, sin_out=0, cos_out=0, out_valid=0.
- Accumulator, per posedge:
  - sync_clr=1: acc<=0.
  - else en=1: acc<=acc+freq_word, modulo 2^ACC_W (natural wrap, no saturation).
  - else: acc holds.
- Stage 1, per posedge:
  - p1 <= acc+phase_off (mod 2^ACC_W), using acc before this edge's update.
  - v1 <= en & ~sync_clr.
- Stage 2, per posedge when v1=1:
  - sin_out/cos_out <= LUT lookup of p1; out_valid <= 1.
  - When v1=0: out_valid <= 0; sin_out/cos_out hold their last value.
- Latency: a sample launched in cycle n (en=1) appears with out_valid=1 after the edge ending cycle n+1. Continuous en gives one sample per cycle.
- sync_clr=1: v1<=0, out_valid<=0, sin_out<=0, cos_out<=0 at the same edge. The next enabled sample uses phase 0+phase_off.
- Phase index: idx = top Q+2 bits of the phase word. Lower ACC_W-Q-2 bits are truncated, no rounding or dither.
  - quad = idx[Q+1:Q]; a = idx[Q-1:0].
- LUT: T[i] = round(AMP*sin(pi/2*i/2^Q)) for i=0..2^Q, i.e. 2^Q+1 entries. Constant, elaboration-time.
  - Default contents: 0, 38, 71, 92, 100.
- Sine unfold by quad:
  - quad 0: T[a]
  - quad 1: T[2^Q-a]
  - quad 2: -T[a]
  - quad 3: -T[2^Q-a]
- Cosine: same unfold applied to idx+2^Q (mod 4*2^Q).
- Outputs are two's complement. Negation of values <= AMP cannot overflow OUT_W.
- freq_word/phase_off changes take effect on the next launched sample. There is no glitch protection beyond that.
- freq_word=0 with en=1: constant output at the current phase, out_valid stays high.

Test Plan:
- Reset: hold rst_n=0 with en=1, then release mid-cycle -> sin_out=0, cos_out=0, out_valid=0 until 2 edges after the first enabled edge. Assert rst_n mid-run -> all outputs 0 immediately, without waiting for a clock edge.
- freq_word=0x1000, phase_off=0, en=1 continuous:
  - out_valid rises at the 2nd edge.
  - sin = 0,38,71,92,100,92,71,38,0,-38,-71,-92,-100,-92,-71,-38, repeating with period 16.
  - cos = 100,92,71,38,0,-38,...
- freq_word=0x2000 -> sin = 0,71,100,71,0,-71,-100,-71. freq_word=0xF000 (wrap) -> sin = 0,-38,-71,-92,-100,...
- phase_off=0x4000, freq_word=0x1000 -> sin sequence equals the cos sequence of the previous scenario (100,92,71,...). Change phase_off to 0 mid-stream -> sin jumps on the 2nd edge after the change.
- en deasserted for 3 cycles mid-run (last sin=92) -> out_valid low, outputs hold 92. On re-enable, the sequence resumes at 100 with no skipped phase.
- sync_clr pulsed together with en=1 mid-run -> outputs 0 and out_valid=0 at that edge. The next samples are 0,38,71,...
